// File: rtl/rr_display_arbiter_if.sv
// Handshake bundle between the requester/switch side and the display arbiter.
// The master drives requests; the slave (arbiter) returns the grant and display code.
interface rr_display_arbiter_if #(
    parameter int N_REQ = 8
);
    localparam int IDX_W = $clog2(N_REQ);

    logic               en;
    logic [N_REQ-1:0]   req;
    logic               done;
    logic [N_REQ-1:0]   gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic [IDX_W:0]     pos;
    logic               timeout;

    modport master (
        output en, req, done,
        input  gnt, gnt_idx, gnt_valid, pos, timeout
    );

    modport slave (
        input  en, req, done,
        output gnt, gnt_idx, gnt_valid, pos, timeout
    );
endinterface

// File: rtl/rr_display_arbiter.sv
// Round-robin arbiter sharing the 7-segment display path between eight requesters.
// Grants are registered, held until release/drop/timeout, and always separated by a GAP cycle.
module rr_display_arbiter #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_display_arbiter_if.slave  bus
);
    localparam int               IDX_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   ptr, ptr_d;
    logic [CNT_W-1:0]   hold_cnt, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               vld_q, vld_d;
    logic               to_q, to_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic               expire;

    // Scan ptr+1 .. ptr+N_REQ so the last holder is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign expire = (hold_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '1;
            hold_cnt <= '0;
            gnt_q    <= '0;
            idx_q    <= '0;
            vld_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            hold_cnt <= cnt_d;
            gnt_q    <= gnt_d;
            idx_q    <= idx_d;
            vld_q    <= vld_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = hold_cnt;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        to_d    = 1'b0;
        case (state)
            IDLE: begin
                gnt_d = '0;
                idx_d = '0;
                vld_d = 1'b0;
                if (bus.en && win_found) begin
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                    idx_d   = win_idx;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!bus.en || bus.done || !bus.req[idx_q] || expire) begin
                    // Timeout only flags when no higher-priority release applies.
                    to_d    = bus.en && !bus.done && bus.req[idx_q] && expire;
                    ptr_d   = idx_q;
                    gnt_d   = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                    state_d = GAP;
                end else if (hold_cnt != '1) begin
                    cnt_d = hold_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                gnt_d   = '0;
                idx_d   = '0;
                vld_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                idx_d   = '0;
                vld_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = vld_q;
    assign bus.timeout   = to_q;
    // Built from registered fields only, so the display code cannot glitch on req.
    assign bus.pos       = {vld_q, idx_q};
endmodule

// File: tb/tb_rr_display_arbiter.sv
// Directed bench for rr_display_arbiter: reset, rotation, timeout, drop, enable,
// done/timeout priority and pointer wrap, with hand-computed expectations.
module tb_rr_display_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_i;

    rr_display_arbiter_if #(.N_REQ(8)) bus ();

    rr_display_arbiter #(.N_REQ(8), .MAX_HOLD(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_gnt(input string tag, input int idx);
        chk({tag, ".gnt"},   {24'd0, bus.gnt}, 32'(8'd1 << idx));
        chk({tag, ".idx"},   {29'd0, bus.gnt_idx}, 32'(idx));
        chk({tag, ".vld"},   {31'd0, bus.gnt_valid}, 32'd1);
        chk({tag, ".pos"},   {28'd0, bus.pos}, 32'(8 + idx));
        chk({tag, ".to"},    {31'd0, bus.timeout}, 32'd0);
    endtask

    task automatic chk_none(input string tag, input logic exp_to);
        chk({tag, ".gnt"},   {24'd0, bus.gnt}, 32'd0);
        chk({tag, ".idx"},   {29'd0, bus.gnt_idx}, 32'd0);
        chk({tag, ".vld"},   {31'd0, bus.gnt_valid}, 32'd0);
        chk({tag, ".pos"},   {28'd0, bus.pos}, 32'd0);
        chk({tag, ".to"},    {31'd0, bus.timeout}, {31'd0, exp_to});
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_out();
        bus.req  = 8'h00;
        bus.done = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        step();
        chk_none("reset", 1'b0);
        step();
        rst_n = 1'b1;

        // Reset asserted mid-grant clears outputs without a clock edge
        bus.en  = 1'b1;
        bus.req = 8'h01;
        step();
        chk_gnt("pre_rst", 0);
        #2 rst_n = 1'b0;
        #1 chk_none("async_rst", 1'b0);
        step();
        rst_n   = 1'b1;
        bus.req = 8'hFF;
        step();
        chk_gnt("first_after_rst", 0);

        // Rotation with done one cycle into each grant
        for (int k = 0; k < 9; k++) begin
            chk_gnt("rot", k % 8);
            bus.done = 1'b1;
            step();
            bus.done = 1'b0;
            chk_none("rot_gap", 1'b0);
            step();
            chk_none("rot_idle", 1'b0);
            step();
        end
        idle_out();

        // Timeout alternation between requesters 2 and 5 (ptr=1)
        bus.req = 8'h24;
        step();
        exp_i = 2;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 16; c++) begin
                chk_gnt("hold", exp_i);
                step();
            end
            chk_none("to_pulse", 1'b1);
            step();
            chk_none("to_idle", 1'b0);
            step();
            exp_i = (exp_i == 2) ? 5 : 2;
        end
        chk_gnt("to_next", 2);
        idle_out();

        // Request drop (ptr=2)
        bus.req = 8'h48;
        step();
        chk_gnt("drop_pre", 3);
        bus.req = 8'h40;
        step();
        chk_none("drop_rel", 1'b0);
        step();
        chk_none("drop_idle", 1'b0);
        step();
        chk_gnt("drop_next", 6);
        idle_out();

        // Disabled arbiter never grants
        bus.en  = 1'b0;
        bus.req = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            step();
            chk_none("en_off", 1'b0);
        end

        // en drop on the expiry cycle: plain release, no timeout
        bus.en = 1'b1;
        step();
        for (int c = 0; c < 15; c++) begin
            chk_gnt("en_hold", 7);
            step();
        end
        chk_gnt("en_last", 7);
        bus.en = 1'b0;
        step();
        chk_none("en_rel", 1'b0);
        bus.en = 1'b1;
        step();
        chk_none("en_idle", 1'b0);
        step();

        // done coincident with expiry: done wins
        for (int c = 0; c < 15; c++) begin
            chk_gnt("dn_hold", 0);
            step();
        end
        chk_gnt("dn_last", 0);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk_none("dn_rel", 1'b0);
        bus.req = 8'h80;
        step();
        step();
        chk_gnt("wrap_pre", 7);

        // Wrap: after releasing 7, requester 0 wins over 7
        bus.done = 1'b1;
        bus.req  = 8'h81;
        step();
        bus.done = 1'b0;
        chk_none("wrap_gap", 1'b0);
        step();
        step();
        chk_gnt("wrap", 0);

        // Single requester is re-granted after GAP+IDLE
        bus.req  = 8'h01;
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk_none("single_gap", 1'b0);
        step();
        chk_none("single_idle", 1'b0);
        step();
        chk_gnt("single_regrant", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rr_display_arbiter.md
Name: rr_display_arbiter

Overview:
- Round-robin arbiter that shares the 8-input priority-encode/7-segment display path between eight requesters.
- It grants exactly one requester at a time and holds that grant until release, request drop, or timeout.
- It drives the encoder-format position code {valid, index} for the existing bcd7seg decoder.
- It sits between the switch/requester inputs and the display path, replacing fixed-priority selection with fair rotation.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 for this revision, with index width 3.
- MAX_HOLD, 16, maximum consecutive cycles a grant may be held; legal range 2..256.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbiter enable; low forces release and blocks new grants.
- req  input  8  request vector; bit i is requester i, level-sensitive.
- done  input  1  release strobe from the current grant holder; sampled only in GRANT.
- gnt  output  8  one-hot grant, registered; all zero when nothing is granted.
- gnt_idx  output  3  binary index of the granted requester; 0 when gnt_valid=0.
- gnt_valid  output  1  high while a grant is active.
- pos  output  4  display code {gnt_valid, gnt_idx}; 4'b0000 when gnt_valid=0.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, ptr=3'd7, hold_cnt=0.
  - gnt=0, gnt_idx=0, gnt_valid=0, pos=0, timeout=0.
  - Reset asserted mid-grant clears everything immediately, with no clock needed.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If en=1 and req!=0, select the winner: the first set bit scanning ptr+1, ptr+2, ... mod 8.
  - On that edge: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=0, go to GRANT.
  - Otherwise stay in IDLE with outputs zero.
- Grant latency: req sampled at edge k → gnt visible after edge k (1 cycle, registered). No combinational path from req to gnt.
- GRANT: hold_cnt increments each cycle, saturating. Release conditions are checked in priority order:
  1. en=0 → release, timeout=0.
  2. done=1 → release, timeout=0.
  3. req[gnt_idx]=0 (requester dropped) → release, timeout=0.
  4. hold_cnt==MAX_HOLD-1 → release, timeout=1 for exactly one cycle, coincident with the gnt-low cycle.
  - If none applies, hold.
- Release edge: gnt=0, gnt_valid=0, gnt_idx=0, ptr=released index, go to GAP.
  - Simultaneous done and timeout: done wins, no timeout pulse.
- GAP: one mandatory idle cycle with all grant outputs zero and timeout=0, then go to IDLE. This guarantees at least one cycle of gnt=0 between consecutive grants.
- Fairness: a continuously requesting input waits at most 7 other grants before service. The winner is never the just-released index unless it is the only requester.
- Single requester: re-granted after IDLE; the cycle is GRANT → GAP → IDLE → GRANT.
- req changes on non-granted bits during GRANT are ignored until the next IDLE.
- pos is combinational from the registered gnt_valid and gnt_idx only; it is glitch-free relative to clk.
- Invariants: gnt is always one-hot or zero; gnt_valid == (gnt!=0); gnt[gnt_idx]==gnt_valid.

Test Plan:
- Reset with rst_n=0 mid-grant (req=8'h01, state GRANT) → all outputs 0 immediately, before the next clk edge. After release with req=8'hFF, en=1 → first grant is gnt=8'h01, idx=0, pos=4'b1000.
- Rotation: req=8'hFF held, done pulsed 1 cycle after each grant → grant indices 0,1,2,...,7,0 in order. Each grant is followed by exactly one GAP cycle plus one IDLE cycle.
- Timeout: req=8'h24 held, done=0, MAX_HOLD=16 → index 2 held 16 cycles, timeout pulses once, then index 5 is granted. The same pattern repeats.
- Request drop: idx 3 granted (req=8'h48), req drops to 8'h40 → gnt=0 the next cycle, no timeout, then idx 6 granted.
- Enable and priority: en=0 with req=8'hFF → no grant ever. en dropped mid-grant in the same cycle as the timeout boundary → release with timeout=0. done and timeout coincident → timeout=0.
- Wrap: ptr at 7 after releasing index 7, req=8'h81 → index 0 granted next, not index 7.
